// File: rtl/adda_ctrl_pkg.sv
// Shared definitions for the ADC/DAC control blocks: default widths and the
// state encoding of the interpolator read controller.
package adda_ctrl_pkg;

    localparam int DATA_WIDTH_DEF  = 14;
    localparam int RATIO_WIDTH_DEF = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_REFILL = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        RUN    = ST_RUN,
        REFILL = ST_REFILL
    } rd_state_t;

endpackage

// File: rtl/interp_rd_ctrl.sv
// Read controller feeding an N-times interpolator: pulls one sample from the
// upstream FIFO every N output slots, holds it for the interpolator, and
// parks in REFILL when the FIFO runs dry until it is half full again.
module interp_rd_ctrl
    import adda_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int RATIO_WIDTH = RATIO_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   above_half,
    input  logic                   empty,
    input  logic [RATIO_WIDTH-1:0] ratio,
    input  logic [DATA_WIDTH-1:0]  fifo_dout,
    output logic                   rd_en,
    output logic [DATA_WIDTH-1:0]  sample_out,
    output logic                   sample_valid,
    output logic [RATIO_WIDTH-1:0] phase,
    output logic                   running,
    output logic                   underflow
);

    localparam logic [RATIO_WIDTH-1:0] RATIO_ONE = RATIO_WIDTH'(1);

    rd_state_t              state;
    logic [RATIO_WIDTH-1:0] ratio_q;
    logic [RATIO_WIDTH-1:0] ratio_eff;
    logic [DATA_WIDTH-1:0]  held_sample;
    logic                   phase_wrap;

    // A ratio of 0 behaves as 1 so the period never collapses to nothing.
    assign ratio_eff  = (ratio == '0) ? RATIO_ONE : ratio;
    assign phase_wrap = (phase == ratio_q - RATIO_ONE);

    // Read strobe: first slot of each input period, data available, enabled.
    assign rd_en = (state == RUN) && (phase == '0) && !empty && ena;

    // NOTE: a continuous assign covers every case by construction, so the
    // FIFO word can be passed straight through in the valid cycle without
    // risking a latch; the register only keeps the word afterwards.
    assign sample_out = sample_valid ? fifo_dout : held_sample;

    // FSM, phase counter, ratio capture and sample-hold register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            phase        <= '0;
            ratio_q      <= RATIO_ONE;
            running      <= 1'b0;
            underflow    <= 1'b0;
            sample_valid <= 1'b0;
            held_sample  <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every branch below sees
            // the pre-edge values of state/phase regardless of statement order.
            sample_valid <= rd_en;
            underflow    <= 1'b0;
            if (sample_valid) begin
                held_sample <= fifo_dout;
            end

            if (!ena) begin
                state   <= IDLE;
                phase   <= '0;
                running <= 1'b0;
            end else begin
                unique case (state)
                    IDLE, REFILL: begin
                        if (above_half) begin
                            state   <= RUN;
                            phase   <= '0;
                            ratio_q <= ratio_eff;
                            running <= 1'b1;
                        end
                    end
                    RUN: begin
                        if ((phase == '0) && empty) begin
                            state     <= REFILL;
                            underflow <= 1'b1;
                            running   <= 1'b0;
                        end else if (phase_wrap) begin
                            phase   <= '0;
                            ratio_q <= ratio_eff;
                        end else begin
                            phase <= phase + RATIO_ONE;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        phase   <= '0;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_interp_rd_ctrl.sv
// Self-checking bench for interp_rd_ctrl: a queue-backed FIFO model feeds the
// DUT and a slot-level reference model predicts every output each cycle.
module tb_interp_rd_ctrl;

    localparam int DW = 14;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ena;
    logic          above_half;
    logic          empty;
    logic [RW-1:0] ratio;
    logic [DW-1:0] fifo_dout;
    logic          rd_en;
    logic [DW-1:0] sample_out;
    logic          sample_valid;
    logic [RW-1:0] phase;
    logic          running;
    logic          underflow;

    interp_rd_ctrl #(.DATA_WIDTH(DW), .RATIO_WIDTH(RW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .above_half   (above_half),
        .empty        (empty),
        .ratio        (ratio),
        .fifo_dout    (fifo_dout),
        .rd_en        (rd_en),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .phase        (phase),
        .running      (running),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // FIFO contents and reference model of the controller
    logic [DW-1:0] fifo_q[$];
    bit            m_run;
    int            m_phase;
    int            m_n;
    bit            m_valid;
    bit            m_uf;
    logic [DW-1:0] m_data;
    logic [DW-1:0] m_held;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_ratio(input logic [RW-1:0] r);
        return (r == 0) ? 1 : int'(r);
    endfunction

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(DW'($urandom));
        empty = (fifo_q.size() == 0);
    endtask

    task automatic model_reset();
        m_run = 0; m_phase = 0; m_n = 1; m_valid = 0; m_uf = 0;
        m_held = '0; m_data = '0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ":phase"},        32'(phase),        32'(m_phase));
        check({tag, ":running"},      32'(running),      32'(m_run));
        check({tag, ":underflow"},    32'(underflow),    32'(m_uf));
        check({tag, ":sample_valid"}, 32'(sample_valid), 32'(m_valid));
        check({tag, ":sample_out"},   32'(sample_out),   32'(m_valid ? m_data : m_held));
    endtask

    // One clock: inputs were set at the preceding falling edge.
    task automatic cycle(input string tag);
        bit            rd_exp;
        bit            e0;
        logic [DW-1:0] word;
        #4;
        e0     = empty;
        rd_exp = m_run && (m_phase == 0) && !empty && ena;
        check({tag, ":rd_en"}, 32'(rd_en), 32'(rd_exp));
        @(posedge clk);
        #1;
        // FIFO presents the read word after the edge that sampled rd_en;
        // otherwise the data bus carries junk the DUT must ignore.
        if (rd_exp) begin
            word      = fifo_q.pop_front();
            fifo_dout = word;
        end else begin
            word      = '0;
            fifo_dout = DW'($urandom);
        end
        empty = (fifo_q.size() == 0);

        if (m_valid) m_held = m_data;
        m_valid = rd_exp;
        if (rd_exp) m_data = word;
        m_uf = 0;
        if (!ena) begin
            m_run = 0; m_phase = 0;
        end else if (m_run) begin
            if (m_phase == 0 && e0) begin
                m_uf = 1; m_run = 0;
            end else begin
                m_phase = m_phase + 1;
                if (m_phase >= m_n) begin
                    m_phase = 0;
                    m_n     = eff_ratio(ratio);
                end
            end
        end else if (above_half) begin
            m_run = 1; m_phase = 0; m_n = eff_ratio(ratio);
        end
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; above_half = 1'b0; ratio = 4'd4;
        fifo_dout = '0; empty = 1'b1;
        model_reset();
        #2;
        check("reset:rd_en", 32'(rd_en), 32'd0);
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        run("idle", 2);

        // ratio 4: read every 4th slot; above_half drop while running ignored
        push_words(16);
        ena = 1'b1; above_half = 1'b1; ratio = 4'd4;
        cycle("r4_entry");
        above_half = 1'b0;
        run("r4", 13);

        // ratio changed 4 -> 2 at phase 1: current period still lasts 4
        for (int i = 0; i < 8 && m_phase != 1; i++) cycle("r4_seek");
        check("seek_phase1", 32'(phase), 32'd1);
        ratio = 4'd2;
        run("r4to2", 10);

        // ratio 0 and 1: read every cycle, phase stays 0
        ena = 1'b0;
        cycle("drop");
        push_words(12);
        ena = 1'b1; above_half = 1'b1; ratio = 4'd0;
        run("r0", 6);
        ratio = 4'd1;
        above_half = 1'b0;
        run("r1", 4);

        // drain to underflow, hold in REFILL, then resume at phase 0
        ratio = 4'd2;
        for (int i = 0; i < 60 && fifo_q.size() > 0; i++) cycle("drain");
        run("underflow", 5);
        push_words(10);
        run("refill_wait", 2);
        above_half = 1'b1;
        run("resume", 6);
        above_half = 1'b0;

        // ena dropped right after a read: the pending sample still lands
        for (int i = 0; i < 8 && !m_valid; i++) cycle("seek_read");
        check("seek_read_hit", 32'(sample_valid), 32'd1);
        for (int i = 0; i < 8 && m_phase != 0; i++) cycle("seek_p0");
        ena = 1'b1;
        cycle("read_slot");
        ena = 1'b0;
        run("ena_drop", 4);

        // empty and ena low together at phase 0: no underflow, go idle
        fifo_q.delete();
        push_words(1);
        ena = 1'b1; above_half = 1'b1; ratio = 4'd1;
        run("last_word", 2);
        above_half = 1'b0;
        ena = 1'b0;
        run("empty_and_off", 2);

        // asynchronous reset between edges while a capture is pending
        push_words(12);
        ena = 1'b1; above_half = 1'b1; ratio = 4'd3;
        cycle("pre_rst");
        for (int i = 0; i < 8 && !m_valid; i++) cycle("pre_rst_read");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst:rd_en", 32'(rd_en), 32'd0);
        check_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1; above_half = 1'b0;
        run("post_rst", 4);
        above_half = 1'b1;
        run("post_rst_start", 5);

        // randomized mix of ratio, enable, half-full and FIFO refills
        for (int i = 0; i < 250; i++) begin
            ena        = ($urandom_range(0, 15) != 0);
            above_half = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) ratio = RW'($urandom);
            if ($urandom_range(0, 2) == 0 && fifo_q.size() < 30) push_words(int'($urandom_range(1, 3)));
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/interp_rd_ctrl.md
INTERP_RD_CTRL -- requirements
Module: interp_rd_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 14, sample width (unsigned).
REQ-002 Parameter RATIO_WIDTH, default 4, width of interpolation-ratio and phase fields.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 ena  in  1  global run enable.
REQ-006 above_half  in  1  upstream FIFO fill >= half; start condition.
REQ-007 empty  in  1  upstream FIFO empty flag.
REQ-008 ratio  in  RATIO_WIDTH  interpolation factor N (output samples per input sample); 0 treated as 1.
REQ-009 fifo_dout  in  DATA_WIDTH  upstream FIFO read data, valid one cycle after rd_en (standard-mode FIFO).
REQ-010 rd_en  out  1  upstream FIFO read strobe.
REQ-011 sample_out  out  DATA_WIDTH  held input sample for downstream interpolator.
REQ-012 sample_valid  out  1  one-cycle pulse: sample_out updated this cycle.
REQ-013 phase  out  RATIO_WIDTH  output-slot index 0..N-1 within current input period.
REQ-014 running  out  1  high while state is RUN.
REQ-015 underflow  out  1  one-cycle pulse on FIFO starvation.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, REFILL.
REQ-017 IDLE -> RUN on a clock edge where ena=1 and above_half=1; phase SHALL be 0 on RUN entry.
REQ-018 In RUN, phase SHALL count 0,1,...,ratio_q-1 then wrap to 0, one step per clock.
REQ-019 ratio_q SHALL be captured from ratio (0 mapped to 1) on RUN entry and on every phase wrap to 0; ratio changes mid-period SHALL have no effect until the next wrap.
REQ-020 rd_en SHALL be combinational: state==RUN and phase==0 and empty==0 and ena==1.
REQ-021 The cycle after rd_en=1, sample_out SHALL load fifo_dout and sample_valid SHALL be 1; otherwise sample_out holds and sample_valid=0 (read-to-valid latency 1 cycle).
REQ-022 In RUN with phase==0 and empty==1: no read, underflow pulses 1 cycle, state -> REFILL, phase held at 0.
REQ-023 REFILL -> RUN on edge where ena=1 and above_half=1; sample_out holds its last value throughout REFILL.
REQ-024 ena=0 in any state SHALL force state -> IDLE at next edge with phase=0; a read issued the previous cycle still completes (sample_valid still pulses).
REQ-025 above_half deasserting while in RUN SHALL be ignored.
REQ-026 With ratio_q=1, rd_en SHALL be asserted every RUN cycle the FIFO is non-empty.
REQ-027 Simultaneous empty=1 and ena=0 at phase 0: ena takes priority -> IDLE, no underflow pulse.
REQ-028 running SHALL equal (state==RUN), registered.

Reset
REQ-029 On rst_n=0 (asynchronous), state=IDLE, phase=0, ratio_q=1, sample_out=0, sample_valid=0, underflow=0, running=0; rd_en=0 follows combinationally.
REQ-030 Reset asserted mid-read SHALL discard the pending capture; no sample_valid after release until a new rd_en.

Structure
REQ-031 State encoding localparams (IDLE, RUN, REFILL) SHALL live in shared package adda_ctrl_pkg; DATA_WIDTH default also there.
REQ-032 Single flat module; no sub-modules (phase counter, FSM, capture register inline).

Verification
REQ-033 ratio=4, FIFO pre-filled to above_half, ena=1 -> rd_en every 4th cycle, phase 0,1,2,3 repeating, sample_valid one cycle after each rd_en, sample_out = FIFO word sequence.
REQ-034 ratio=0 and ratio=1 -> rd_en continuous while non-empty, phase constant 0.
REQ-035 ratio changed 4->2 when phase=1 -> periods continue 2,3 then next period length 2.
REQ-036 FIFO drains (empty=1 at phase 0) -> underflow pulse 1 cycle, running=0, sample_out holds; refill to above_half -> RUN resumes, phase starts 0.
REQ-037 ena dropped the cycle after rd_en -> sample_valid still pulses once, state IDLE, rd_en=0 thereafter.
REQ-038 rst_n asserted mid-RUN, asynchronously between edges -> all outputs 0 immediately; after release, nothing until above_half=1.
